// File: rtl/hififo_test_pkg.sv
// ============================================================================
// Package     : hififo_test_pkg
// Description : Shared register offsets, ctrl bit indices and generator state
//               encoding for the hififo test-pattern source/sink.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hififo_test_pkg;

    // Register word offsets relative to PIO_BASE
    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_SEED = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CLR  = 2'd3;

    // ctrl register bit positions
    localparam int CTRL_GEN   = 0;
    localparam int CTRL_LOOP  = 1;
    localparam int CTRL_CHECK = 2;

    // Generator state encoding
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        GEN  = 1'b1
    } gen_state_e;

endpackage : hififo_test_pkg

`default_nettype wire

// File: rtl/hififo_seq_checker.sv
// ============================================================================
// Module      : hififo_seq_checker
// Description : Sequence checker for the fpc stream. Tracks the expected
//               counter value, resyncs on mismatch and keeps a saturating
//               mismatch count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hififo_seq_checker (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable_i,
    input  logic        consume_i,
    input  logic [63:0] data_i,
    input  logic        seed_load_i,
    input  logic [63:0] seed_i,
    input  logic        clear_i,
    output logic [31:0] error_count_o
);

    logic [63:0] expected_q;
    logic [31:0] err_cnt_q;
    logic        compare_w;
    logic        mismatch_w;

    // A seed load in the same cycle as a consumed word suppresses the compare
    assign compare_w  = enable_i && consume_i && !seed_load_i;
    assign mismatch_w = compare_w && (data_i != expected_q);

    // Expected-value tracking with resync after a mismatch
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            expected_q <= 64'd0;
        end else if (seed_load_i) begin
            expected_q <= seed_i;
        end else if (mismatch_w) begin
            expected_q <= data_i + 64'd1;
        end else if (compare_w) begin
            expected_q <= expected_q + 64'd1;
        end
    end

    // Saturating mismatch counter; a clear beats a simultaneous mismatch
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            err_cnt_q <= 32'd0;
        end else if (clear_i) begin
            err_cnt_q <= 32'd0;
        end else if (mismatch_w && (err_cnt_q != 32'hFFFF_FFFF)) begin
            err_cnt_q <= err_cnt_q + 32'd1;
        end
    end

    assign error_count_o = err_cnt_q;

endmodule : hififo_seq_checker

`default_nettype wire

// File: rtl/hififo_test_pattern.sv
// ============================================================================
// Module      : hififo_test_pattern
// Description : Test-pattern source/sink on the hififo_pcie channel-0 user
//               FIFO ports: counting generator, fpc->tpc loopback and fpc
//               sequence checker, all controlled through PIO writes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hififo_test_pattern
    import hififo_test_pkg::*;
#(
    parameter logic [12:0] PIO_BASE = 13'd16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        pio_write_valid,
    input  logic [63:0] pio_write_data,
    input  logic [12:0] pio_address,
    output logic [63:0] tpc_data,
    output logic        tpc_write,
    input  logic        tpc_ready,
    input  logic [63:0] fpc_data,
    output logic        fpc_read,
    input  logic        fpc_valid,
    output logic [31:0] error_count,
    output logic        gen_busy,
    output logic [3:0]  led
);

    logic [12:0] addr_off_w;
    logic        addr_hit_w;
    logic        ctrl_wr_w;
    logic        seed_wr_w;
    logic        len_wr_w;
    logic        clr_wr_w;
    logic        gen_mode_w;
    logic        loop_mode_w;
    logic        consume_w;

    gen_state_e  state_q;
    logic [2:0]  ctrl_q;
    logic [31:0] length_q;
    logic [31:0] remaining_q;
    logic        pending_q;
    logic [63:0] gen_value_q;
    logic [63:0] tpc_data_q;
    logic        tpc_write_q;
    logic        fpc_read_q;

    // Register window decode: the offset must fall in 0..3 above PIO_BASE
    assign addr_off_w  = pio_address - PIO_BASE;
    assign addr_hit_w  = pio_write_valid && (pio_address >= PIO_BASE) && (addr_off_w[12:2] == 11'd0);
    assign ctrl_wr_w   = addr_hit_w && (addr_off_w[1:0] == REG_CTRL);
    assign seed_wr_w   = addr_hit_w && (addr_off_w[1:0] == REG_SEED);
    assign len_wr_w    = addr_hit_w && (addr_off_w[1:0] == REG_LEN);
    assign clr_wr_w    = addr_hit_w && (addr_off_w[1:0] == REG_CLR);

    // Loopback takes priority over the generator
    assign loop_mode_w = ctrl_q[CTRL_LOOP];
    assign gen_mode_w  = ctrl_q[CTRL_GEN] && !ctrl_q[CTRL_LOOP];
    assign consume_w   = fpc_read_q && fpc_valid;

    // Control registers, generator FSM and registered FIFO-side outputs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ctrl_q      <= 3'd0;
            length_q    <= 32'd0;
            remaining_q <= 32'd0;
            pending_q   <= 1'b0;
            gen_value_q <= 64'd0;
            tpc_data_q  <= 64'd0;
            tpc_write_q <= 1'b0;
            fpc_read_q  <= 1'b0;
        end else begin
            if (ctrl_wr_w) begin
                ctrl_q <= pio_write_data[2:0];
            end
            if (len_wr_w) begin
                length_q <= pio_write_data[31:0];
            end

            tpc_write_q <= 1'b0;

            // fpc side: follow tpc slack in loopback, drain freely when only checking
            if (loop_mode_w) begin
                fpc_read_q  <= tpc_ready;
                tpc_write_q <= consume_w;
                if (consume_w) begin
                    tpc_data_q <= fpc_data;
                end
            end else begin
                fpc_read_q <= ctrl_q[CTRL_CHECK];
            end

            case (state_q)
                IDLE: begin
                    if (gen_mode_w && pending_q) begin
                        state_q     <= GEN;
                        pending_q   <= 1'b0;
                        remaining_q <= length_q;
                    end
                end
                GEN: begin
                    if (!gen_mode_w) begin
                        state_q <= IDLE;
                    end else if (tpc_ready) begin
                        tpc_write_q <= 1'b1;
                        tpc_data_q  <= gen_value_q;
                        gen_value_q <= gen_value_q + 64'd1;
                        // Length 0 runs forever; otherwise stop after the last word
                        if (length_q != 32'd0) begin
                            remaining_q <= remaining_q - 32'd1;
                            if (remaining_q == 32'd1) begin
                                state_q <= IDLE;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            // A new request placed after the FSM so it is never lost to a start
            if (ctrl_wr_w || len_wr_w) begin
                pending_q <= 1'b1;
            end
            // Seed overrides any increment in the same cycle
            if (seed_wr_w) begin
                gen_value_q <= pio_write_data;
            end
        end
    end

    hififo_seq_checker u_chk (
        .clock         (clock),
        .reset_n       (reset_n),
        .enable_i      (ctrl_q[CTRL_CHECK]),
        .consume_i     (consume_w),
        .data_i        (fpc_data),
        .seed_load_i   (seed_wr_w),
        .seed_i        (pio_write_data),
        .clear_i       (clr_wr_w),
        .error_count_o (error_count)
    );

    assign tpc_data  = tpc_data_q;
    assign tpc_write = tpc_write_q;
    assign fpc_read  = fpc_read_q;
    assign gen_busy  = (state_q == GEN);
    assign led       = {(error_count != 32'd0), gen_busy, ctrl_q[1:0]};

endmodule : hififo_test_pattern

`default_nettype wire

// File: doc/hififo_test_pattern.md
# hififo_test_pattern

Test-pattern source and sink attached to the user-side FIFO ports of `hififo_pcie` (channel 0). It drives the to-PC FIFO (tpc) with a counting pattern or with looped-back from-PC (fpc) data, and consumes and checks the fpc stream against an expected counter. All control comes over PIO writes. It replaces ad-hoc test logic at the top level and provides the DMA bring-up and throughput test path.

## Interface
- `PIO_BASE`, default 13'd16: PIO word address of register 0; registers occupy `PIO_BASE`..`PIO_BASE+3`.
- `clock`  in  1  FIFO/PIO clock; same clock as `hififo_pcie` `fifo_clock`.
- `reset_n`  in  1  synchronous, active-low reset.
- `pio_write_valid`  in  1  PIO write strobe.
- `pio_write_data`  in  64  PIO write data.
- `pio_address`  in  13  PIO word address.
- `tpc_data`  out  64  data to tpc FIFO.
- `tpc_write`  out  1  tpc write strobe; one word per high cycle.
- `tpc_ready`  in  1  tpc can accept ≥2 more words.
- `fpc_data`  in  64  data from fpc FIFO.
- `fpc_read`  out  1  fpc read enable.
- `fpc_valid`  in  1  `fpc_data` valid; a word is consumed on each cycle with `fpc_read && fpc_valid`.
- `error_count`  out  32  checker mismatch count, saturating.
- `gen_busy`  out  1  generator has words outstanding.
- `led`  out  4  {`error_count!=0`, `gen_busy`, `ctrl[1:0]`}.

## Operation
- PIO registers (decoded only on `pio_write_valid`):
  - `PIO_BASE+0`: ctrl[2:0]. bit0 generate, bit1 loopback, bit2 check. If both bit1 and bit0 are set, loopback wins.
  - `PIO_BASE+1`: seed. Loads both the generator value and the checker's expected value.
  - `PIO_BASE+2`: length[31:0]. Number of words to generate; 0 means unlimited. A write starts a new run.
  - `PIO_BASE+3`: any write clears `error_count`.
- Generator states:
  - IDLE → GEN when bit0 is set (and bit1 is clear) and there is a pending run. A write to length or ctrl sets the pending run.
  - GEN: each cycle with registered `tpc_ready` high, emit `tpc_data <= gen_value`, then `gen_value += 1`, mod 2^64 wrap.
  - GEN → IDLE when `remaining` reaches 0 (if length is non-zero) or when bit0 is cleared. The word in flight still completes.
  - `gen_busy` = (state == GEN).
- Loopback (bit1):
  - `fpc_read <= tpc_ready`.
  - `tpc_write <= fpc_read && fpc_valid`.
  - `tpc_data <= fpc_data`.
  - The generator is held in IDLE.
- Checker (bit2): independent of the mode bits. It monitors every consumed fpc word.
  - If check is set and loopback is clear, `fpc_read` is 1 continuously.
  - If neither loopback nor check is set, `fpc_read` is 0.
  - Mismatch (`fpc_data != expected`): `error_count` += 1, saturating at 2^32-1. Then `expected <= fpc_data + 1` (resync).
  - Match: `expected += 1`.
- Simultaneous events:
  - A seed write in the same cycle as a consumed word: seed wins for both `expected` and `gen_value`, and that word is not compared.
  - Clear in the same cycle as a mismatch: result is 0.
- Reset values: `tpc_write`=0, `tpc_data`=0, `fpc_read`=0, ctrl=0, seed/`gen_value`/`expected`=0, length=0, `error_count`=0, state IDLE, `led`=0.
- Reset mid-run drops all state. The tpc word in flight is not completed.

## Timing
- All outputs are registered.
- Generator: `tpc_ready` high in cycle N gives `tpc_write` in cycle N+1. Sustained throughput is 1 word/cycle.
- Loopback: latency 1 cycle from the fpc consume to `tpc_write`.
- Backpressure: when `tpc_ready` drops in cycle N, at most one further word is written (cycle N+1). This is within the 2-word slack.
- Register writes take effect the cycle after `pio_write_valid`.
- `error_count` updates 1 cycle after the consumed word.
- `remaining` decrements on each `tpc_write`. With length=L, exactly L words are written.

## Structure
- Shared package `hififo_test_pkg`:
  - register offset constants `REG_CTRL=0`, `REG_SEED=1`, `REG_LEN=2`, `REG_CLR=3`;
  - ctrl bit indices;
  - generator state enum {IDLE, GEN}.
- One sub-module, `hififo_seq_checker`. It holds the expected counter, the compare, and the saturating `error_count` with seed load and clear inputs.

## Test plan
- ctrl=1, seed=0x100, length=4, `tpc_ready` held 1 → `tpc_data` = 0x100, 0x101, 0x102, 0x103 on 4 consecutive writes, then `gen_busy`=0 and no further writes.
- ctrl=1, length=0, `tpc_ready` toggled 1/0 every 3 cycles → monotonic stream with no gaps or duplicates, and ≤1 write after each ready fall.
- ctrl=2, fpc supplies 0xA5, 0x5A with `fpc_valid`, `tpc_ready`=1 → `tpc_write` 1 cycle after each consume, with identical data.
- ctrl=4, seed=0, fpc supplies 0, 1, 7, 8 → `error_count`=1. A following word 9 adds no error (resynced).
- `error_count` at 0xFFFFFFFF plus a mismatch → stays 0xFFFFFFFF. A write to `PIO_BASE+3` → 0 the next cycle.
- Generation running at word 5 of 10, `reset_n`=0 for 1 cycle → all outputs 0 and state IDLE. No writes resume until a new length/ctrl write.
